trace_capture_unit: RTL and testbench
=====================================

TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

Interface
REQ-001 Parameter DATA_W, default 28, SHALL set the processor data/payload width.
REQ-002 Parameter OPC_W, default 5, SHALL set the opcode width and the trace field width.
REQ-003 Parameter ADDR_W, default 8, SHALL set the memory address width.
REQ-004 Parameter NUM_CH, default 4, SHALL set the watch-channel count (1..2^OPC_W).
REQ-005 Parameter DEPTH, default 16, SHALL set the trace FIFO depth (power of 2, >=2).
REQ-006 Parameter CAPTURE_LEN, default 64, SHALL set the entry count that ends a capture.
REQ-007 clk in 1: single clock; all logic on rising edge.
REQ-008 reset in 1: asynchronous, active-low reset.
REQ-009 opcode in OPC_W, ir_write in 1, pc in DATA_W: processor fetch tap; ir_write high = one fetch.
REQ-010 mem_we in 1, mem_addr in ADDR_W, mem_wdata in DATA_W: processor memory write tap.
REQ-011 cfg_we in 1, cfg_ch in clog2(NUM_CH), cfg_addr in ADDR_W, cfg_en in 1: watch-channel programming.
REQ-012 arm in 1, stop in 1, clear in 1, trig_opcode in OPC_W: capture control, 1-cycle pulses.
REQ-013 t_valid out 1, t_data out ENTRY_W, t_ready in 1: trace readout handshake.
REQ-014 state out 2, level out clog2(DEPTH)+1, ovf_cnt out 8: status.

Function
REQ-015 ENTRY_W SHALL be 1+OPC_W+DATA_W; entry = {type, field, payload}.
REQ-016 Instruction entry: type=0, field=opcode, payload=pc.
REQ-017 Watch entry: type=1, field=channel index zero-extended, payload=mem_wdata.
REQ-018 States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-019 IDLE/DONE + arm -> ARMED; FIFO contents kept.
REQ-020 ARMED + ir_write with opcode==trig_opcode -> CAPTURE; that fetch is the first entry.
REQ-021 CAPTURE -> DONE on stop, or when the CAPTURE_LEN-th entry is pushed.
REQ-022 clear SHALL empty the FIFO, zero ovf_cnt and force IDLE; clear beats arm/stop/trigger in the same cycle.
REQ-023 In CAPTURE, each ir_write SHALL push an instruction entry.
REQ-024 In CAPTURE, mem_we with mem_addr equal to an enabled channel address SHALL produce a watch hit; the lowest matching channel wins.
REQ-025 Instruction and watch hit in the same cycle: instruction pushed; hit held in a 1-entry skid register and pushed the next cycle.
REQ-026 A skid entry SHALL push before any new event; a new hit while the skid is occupied is dropped and counted.
REQ-027 A push to a full FIFO SHALL be dropped, and ovf_cnt incremented, saturating at 255.
REQ-028 An entry pushed in cycle N SHALL be visible on t_data/t_valid at cycle N+1 when the FIFO was empty.
REQ-029 Pop on t_valid&&t_ready; push and pop in the same cycle at full SHALL succeed with level unchanged.
REQ-030 t_data SHALL stay stable while t_valid&&!t_ready.
REQ-031 Pointers SHALL wrap modulo DEPTH; level = number of stored entries.
REQ-032 cfg_we SHALL write channel cfg_ch's address/enable in any state, effective next cycle.

Reset
REQ-033 Reset SHALL force: state IDLE, FIFO empty, t_valid 0, level 0, ovf_cnt 0, skid empty, capture count 0, all channels disabled with address 0.
REQ-034 Reset asserted mid-capture SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-035 With TRACE_TIMESTAMP_EN defined, a free-running 16-bit cycle counter (reset 0, wraps) SHALL be appended as t_data LSBs (ENTRY_W+16); the timestamp is taken at the event cycle, and a skid entry keeps its original stamp.
REQ-036 Without TRACE_TIMESTAMP_EN, there SHALL be no counter and ENTRY_W as in REQ-015.

Verification
REQ-037 arm, then fetches opcode 3,7,3 with trig_opcode=7, pc 10,11,12 -> entries {0,7,11},{0,3,12}; state=2.
REQ-038 ch0=0x30 enabled, CAPTURE, mem_we addr 0x30 data 0x5 with ir_write opcode 2 pc 4 in the same cycle -> {0,2,4} then {1,0,0x5} on consecutive cycles.
REQ-039 DEPTH=16, t_ready=0, 20 fetches in CAPTURE -> level=16, ovf_cnt=4, first 16 entries read intact.
REQ-040 CAPTURE_LEN=3, 5 fetches -> 3 entries, state=3; arm -> state=1, entries retained.
REQ-041 reset low mid-capture with level=5 -> t_valid=0, level=0, state=0 before the next edge; clear+arm in the same cycle -> state=0.

Source files
------------

// File: rtl/trace_capture_unit.sv
// Trace capture unit: records instruction fetches and watched memory writes into a FIFO.
// Optional TRACE_TIMESTAMP_EN appends a 16-bit cycle stamp to each entry's LSBs.
module trace_capture_unit #(
  parameter int DATA_W      = 28,
  parameter int OPC_W       = 5,
  parameter int ADDR_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 64,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = $clog2(DEPTH) + 1,
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W       = 16,
`else
  localparam int TS_W       = 0,
`endif
  localparam int ENTRY_W    = 1 + OPC_W + DATA_W + TS_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic               ir_write_i,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic               mem_we_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic               cfg_we_i,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [ADDR_W-1:0]  cfg_addr_i,
  input  logic               cfg_en_i,
  input  logic               arm_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic [OPC_W-1:0]   trig_opcode_i,
  output logic               t_valid_o,
  output logic [ENTRY_W-1:0] t_data_o,
  input  logic               t_ready_i,
  output logic [1:0]         state_o,
  output logic [LVL_W-1:0]   level_o,
  output logic [7:0]         ovf_cnt_o
);
  localparam int CNT_W = $clog2(CAPTURE_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ch_addr_q [NUM_CH];
  logic [NUM_CH-1:0]   ch_en_q;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ENTRY_W-1:0]  skid_q, skid_d;
  logic                skid_v_q, skid_v_d;

  logic                hit_found, hit_ev, instr_ev, trig_fire, hit_drop;
  logic [CH_W-1:0]     hit_ch;
  logic [ENTRY_W-1:0]  instr_entry, hit_entry, push_entry;
  logic                push_req, push_ok, pop, full, drop_full, cap_push, len_hit, arm_ok;
  logic [8:0]          ovf_sum;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + 16'd1;
  end
  assign instr_entry = {1'b0, opcode_i, pc_i, ts_q};
  assign hit_entry   = {1'b1, OPC_W'(hit_ch), mem_wdata_i, ts_q};
`else
  assign instr_entry = {1'b0, opcode_i, pc_i};
  assign hit_entry   = {1'b1, OPC_W'(hit_ch), mem_wdata_i};
`endif

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    hit_found = 1'b0;
    hit_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en_q[i] && (ch_addr_q[i] == mem_addr_i)) begin
        hit_found = 1'b1;
        hit_ch    = CH_W'(i);
      end
    end
  end

  assign trig_fire = (state_q == ARMED) && ir_write_i && (opcode_i == trig_opcode_i);
  assign instr_ev  = ir_write_i && ((state_q == CAPTURE) || trig_fire);
  assign hit_ev    = mem_we_i && (state_q == CAPTURE) && hit_found;

  // One push per cycle; a pending skid entry always goes first to keep order.
  always_comb begin
    push_req   = 1'b0;
    push_entry = '0;
    skid_d     = skid_q;
    skid_v_d   = skid_v_q;
    hit_drop   = 1'b0;
    if (skid_v_q) begin
      push_req   = 1'b1;
      push_entry = skid_q;
      skid_v_d   = 1'b0;
      if (instr_ev) begin
        skid_d   = instr_entry;
        skid_v_d = 1'b1;
      end
      hit_drop = hit_ev;
    end else if (instr_ev) begin
      push_req   = 1'b1;
      push_entry = instr_entry;
      if (hit_ev) begin
        skid_d   = hit_entry;
        skid_v_d = 1'b1;
      end
    end else if (hit_ev) begin
      push_req   = 1'b1;
      push_entry = hit_entry;
    end
  end

  assign t_valid_o = (level_q != '0);
  assign t_data_o  = mem_q[rd_ptr_q];
  assign full      = (level_q == LVL_W'(DEPTH));
  assign pop       = t_valid_o && t_ready_i;
  assign push_ok   = push_req && !clear_i && (!full || pop);
  assign drop_full = push_req && !clear_i && full && !pop;
  assign cap_push  = push_ok && ((state_q == CAPTURE) || trig_fire);
  assign len_hit   = cap_push && (cnt_q == CNT_W'(CAPTURE_LEN - 1));
  assign arm_ok    = arm_i && !clear_i && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (arm_i) state_d = ARMED;
        ARMED:      if (trig_fire) state_d = len_hit ? DONE : CAPTURE;
        CAPTURE:    if (stop_i || len_hit) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);
    ovf_sum = {1'b0, ovf_q} + 9'(drop_full) + 9'(hit_drop && !clear_i);
    ovf_d   = (ovf_sum > 9'd255) ? 8'hFF : ovf_sum[7:0];
    cnt_d   = cnt_q;
    if (arm_ok)        cnt_d = '0;
    else if (cap_push) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      cnt_q    <= '0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        ovf_q    <= '0;
        cnt_q    <= '0;
        skid_v_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        level_q  <= level_d;
        ovf_q    <= ovf_d;
        cnt_q    <= cnt_d;
        skid_v_q <= skid_v_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) ch_addr_q[i] <= '0;
      ch_en_q <= '0;
    end else if (cfg_we_i && (int'(cfg_ch_i) < NUM_CH)) begin
      ch_addr_q[cfg_ch_i] <= cfg_addr_i;
      ch_en_q[cfg_ch_i]   <= cfg_en_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign state_o   = state_q;
  assign level_o   = level_q;
  assign ovf_cnt_o = ovf_q;
endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit: a default instance plus a CAPTURE_LEN=3 instance.
module tb_trace_capture_unit;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif
  localparam int EW = 34 + TS_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        ir_write;
  logic [27:0] pc;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [27:0] mem_wdata;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_addr;
  logic        cfg_en;
  logic        arm, stop, clear;
  logic [4:0]  trig_opcode;
  logic        t_ready_a, t_ready_b;
  logic        t_valid_a, t_valid_b;
  logic [EW-1:0] t_data_a, t_data_b;
  logic [1:0]  state_a, state_b;
  logic [4:0]  level_a, level_b;
  logic [7:0]  ovf_a, ovf_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trace_capture_unit dut_a (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .ir_write_i(ir_write), .pc_i(pc),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_addr_i(cfg_addr), .cfg_en_i(cfg_en),
    .arm_i(arm), .stop_i(stop), .clear_i(clear), .trig_opcode_i(trig_opcode),
    .t_valid_o(t_valid_a), .t_data_o(t_data_a), .t_ready_i(t_ready_a),
    .state_o(state_a), .level_o(level_a), .ovf_cnt_o(ovf_a)
  );

  trace_capture_unit #(.CAPTURE_LEN(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .ir_write_i(ir_write), .pc_i(pc),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_addr_i(cfg_addr), .cfg_en_i(cfg_en),
    .arm_i(arm), .stop_i(stop), .clear_i(clear), .trig_opcode_i(trig_opcode),
    .t_valid_o(t_valid_b), .t_data_o(t_data_b), .t_ready_i(t_ready_b),
    .state_o(state_b), .level_o(level_b), .ovf_cnt_o(ovf_b)
  );

  function automatic logic [63:0] mk(input logic t, input logic [4:0] f, input logic [27:0] p);
    mk = {30'd0, t, f, p};
  endfunction

  function automatic logic [63:0] base_a();
    base_a = 64'(t_data_a) >> TS_W;
  endfunction

  function automatic logic [63:0] base_b();
    base_b = 64'(t_data_b) >> TS_W;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [4:0] op, input logic [27:0] p);
    ir_write = 1'b1; opcode = op; pc = p;
    cycle();
    ir_write = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  task automatic pulse_arm(input logic [4:0] trig);
    trig_opcode = trig; arm = 1'b1; cycle(); arm = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] addr, input logic en);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_en = en;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic pop_a_check(input string tag, input logic [63:0] exp);
    check(tag, base_a(), exp);
    t_ready_a = 1'b1; cycle(); t_ready_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; ir_write = 1'b0; pc = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_en = 1'b0;
    arm = 1'b0; stop = 1'b0; clear = 1'b0; trig_opcode = '0;
    t_ready_a = 1'b0; t_ready_b = 1'b0;

    // Reset state
    #2;
    check("rst_state", 64'(state_a), 64'd0);
    check("rst_level", 64'(level_a), 64'd0);
    check("rst_valid", 64'(t_valid_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    #10 rst_n = 1'b1;
    cycle();

    // Trigger on opcode 7: first entry is the triggering fetch
    pulse_arm(5'd7);
    check("arm_state", 64'(state_a), 64'd1);
    fetch(5'd3, 28'd10);
    check("pre_trig_level", 64'(level_a), 64'd0);
    fetch(5'd7, 28'd11);
    check("trig_valid_next", 64'(t_valid_a), 64'd1);
    check("trig_entry", base_a(), mk(1'b0, 5'd7, 28'd11));
    fetch(5'd3, 28'd12);
    check("cap_state", 64'(state_a), 64'd2);
    check("cap_level", 64'(level_a), 64'd2);
    pop_a_check("rd0", mk(1'b0, 5'd7, 28'd11));
    pop_a_check("rd1", mk(1'b0, 5'd3, 28'd12));
    check("drained_valid", 64'(t_valid_a), 64'd0);

    // Watch channels, skid ordering, skid drop, disabled channel
    pulse_clear();
    cfg(2'd0, 8'h30, 1'b1);
    cfg(2'd1, 8'h30, 1'b1);
    cfg(2'd2, 8'h40, 1'b1);
    cfg(2'd3, 8'h50, 1'b0);
    pulse_arm(5'd7);
    fetch(5'd7, 28'd1);
    check("w_level1", 64'(level_a), 64'd1);
    ir_write = 1'b1; opcode = 5'd2; pc = 28'd4;
    mem_we = 1'b1; mem_addr = 8'h30; mem_wdata = 28'h5;
    cycle();
    ir_write = 1'b0;
    check("w_level2", 64'(level_a), 64'd2);
    mem_addr = 8'h40; mem_wdata = 28'h9;
    cycle();
    check("w_skid_push", 64'(level_a), 64'd3);
    check("w_skid_drop_ovf", 64'(ovf_a), 64'd1);
    mem_addr = 8'h50; mem_wdata = 28'h1;
    cycle();
    check("w_disabled_ch", 64'(level_a), 64'd3);
    mem_addr = 8'h40; mem_wdata = 28'h9;
    cycle();
    mem_we = 1'b0;
    check("w_level4", 64'(level_a), 64'd4);
    cycle();
    check("w_stable", base_a(), mk(1'b0, 5'd7, 28'd1));
    pop_a_check("w_rd0", mk(1'b0, 5'd7, 28'd1));
    pop_a_check("w_rd1", mk(1'b0, 5'd2, 28'd4));
    pop_a_check("w_rd2", mk(1'b1, 5'd0, 28'd5));
    pop_a_check("w_rd3", mk(1'b1, 5'd2, 28'd9));
    check("w_empty", 64'(t_valid_a), 64'd0);

    // Overflow: 20 fetches into a 16-deep FIFO with no readout
    pulse_clear();
    check("clr_ovf", 64'(ovf_a), 64'd0);
    pulse_arm(5'd1);
    for (int i = 0; i < 20; i++) fetch(5'd1, 28'(i));
    check("ovf_level", 64'(level_a), 64'd16);
    check("ovf_cnt", 64'(ovf_a), 64'd4);
    // Push and pop together at full
    t_ready_a = 1'b1;
    fetch(5'd1, 28'd100);
    t_ready_a = 1'b0;
    check("full_pp_level", 64'(level_a), 64'd16);
    check("full_pp_ovf", 64'(ovf_a), 64'd4);
    for (int i = 1; i < 16; i++) pop_a_check("ovf_rd", mk(1'b0, 5'd1, 28'(i)));
    pop_a_check("ovf_rd_last", mk(1'b0, 5'd1, 28'd100));
    check("ovf_empty", 64'(level_a), 64'd0);

    // Capture length of 3 on dut_b; stop on dut_a
    pulse_clear();
    pulse_arm(5'd1);
    for (int i = 0; i < 5; i++) fetch(5'd1, 28'(20 + i));
    check("len_state_b", 64'(state_b), 64'd3);
    check("len_level_b", 64'(level_b), 64'd3);
    check("len_state_a", 64'(state_a), 64'd2);
    check("len_level_a", 64'(level_a), 64'd5);
    pulse_arm(5'd1);
    check("rearm_state_b", 64'(state_b), 64'd1);
    check("rearm_level_b", 64'(level_b), 64'd3);
    stop = 1'b1; cycle(); stop = 1'b0;
    check("stop_state_a", 64'(state_a), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("len_rd_b", base_b(), mk(1'b0, 5'd1, 28'(20 + i)));
      t_ready_b = 1'b1; cycle(); t_ready_b = 1'b0;
    end
    check("len_empty_b", 64'(t_valid_b), 64'd0);

    // Asynchronous reset mid-capture
    pulse_clear();
    pulse_arm(5'd1);
    for (int i = 0; i < 5; i++) fetch(5'd1, 28'(40 + i));
    check("ar_level_pre", 64'(level_a), 64'd5);
    check("ar_state_pre", 64'(state_a), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(t_valid_a), 64'd0);
    check("ar_level", 64'(level_a), 64'd0);
    check("ar_state", 64'(state_a), 64'd0);
    #2 rst_n = 1'b1;
    cycle();
    // Clear wins over arm
    clear = 1'b1; arm = 1'b1; cycle(); clear = 1'b0; arm = 1'b0;
    check("clr_beats_arm", 64'(state_a), 64'd0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
